chaos_serializer: RTL and testbench
===================================

# chaos_serializer

Downstream stage of the chaos wire shuffler. It accepts one shuffled expanded-chaos word per handshake and emits it as a serial chip stream toward the DCSK modulator, LSB first, with an end-of-word marker. Double buffering (holding register plus shift register) keeps the chip stream gap-free while upstream computes the next word.

## Interface
- WIDTH, 256, bits per shuffled chaos word; matches the 256-entry shuffle matrix.
- CNT_W, 16, width of the emitted-word counter.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous flush; highest priority after reset.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  serializer can accept a word (registered).
- s_data  in  WIDTH  shuffled chaos word.
- m_valid  out  1  chip valid.
- m_ready  in  1  modulator accepts chip.
- m_bit  out  1  current chip.
- m_last  out  1  current chip is bit WIDTH-1 of its word.
- words_out  out  CNT_W  count of fully emitted words, wraps modulo 2^CNT_W.

## Operation
- Holding buffer: HB data plus hb_full flag. Shift register: SR data, sr_full flag, bit index idx (clog2(WIDTH) bits).
- Accept: s_valid && s_ready at an edge captures s_data into HB and sets hb_full.
- s_ready is a register: next value = !hb_full_next. It cannot be high while HB holds data, even in the cycle HB drains.
- m_bit = SR[0]; m_valid = sr_full; m_last = sr_full && (idx == WIDTH-1).
- Chip handshake (m_valid && m_ready): SR shifts right by 1, idx increments.
  - On a handshake with m_last: idx returns to 0, words_out increments, and sr_full clears unless a reload happens in the same edge.
- Reload (HB to SR): occurs at an edge when hb_full && (!sr_full || (m_valid && m_ready && m_last)).
  - SR takes HB, idx = 0, sr_full = 1, hb_full = 0.
  - A capture into HB in the same edge is impossible because s_ready was 0.
- Backpressure: while m_valid && !m_ready, m_bit, m_last, SR and idx hold.
- Simultaneous events:
  - Last-chip handshake plus full HB gives back-to-back words with no idle cycle.
  - Last-chip handshake plus empty HB drops m_valid next cycle.
- clr: at the edge it is sampled high, hb_full, sr_full and idx go to 0 and words_out goes to 0.
  - Handshakes in that cycle are discarded and the in-flight word is lost.
  - s_ready is 1 after that edge.
- words_out wraps from 2^CNT_W-1 to 0 silently.

## Timing
- Reset (rst_n low, asynchronous): s_ready=0, m_valid=0, m_bit=0, m_last=0, words_out=0, hb_full=sr_full=0, idx=0, data registers 0.
- s_ready rises at the first clk edge after rst_n deasserts.
- Latency: word captured at edge k, with SR empty, gives m_valid=1 and m_bit=s_data[0] after edge k+1.
- s_ready returns to 1 after edge k+1 once HB has drained.
- Throughput: one chip per cycle with m_ready held high; WIDTH cycles per word; no bubble between words when upstream refills HB within WIDTH-1 cycles.
- words_out updates at the edge of the last-chip handshake.
- Reset asserted mid-word: all outputs go to reset values immediately; no partial word is resumed.

## Test plan
- Single word, m_ready=1:
  - Stimulus: s_data = 256'h1 << 7 | 1'b1.
  - Expect m_bit=1 at chips 0 and 7 and 0 elsewhere.
  - Expect m_last only on chip 255, words_out=1, m_valid=0 afterwards.
- Back-to-back:
  - Stimulus: word A all-ones, then word B all-zeros offered immediately, m_ready=1.
  - Expect 256 ones then 256 zeros with m_valid continuously 1.
  - Expect s_ready=0 while HB is full; words_out=2.
- Backpressure:
  - Stimulus: word 0xA5 in the low bits; m_ready toggles 1,0,0,1 repeatedly.
  - Expect m_bit and m_last stable during stalls and the sequence 1,0,1,0,0,1,0,1 on accepted chips.
  - Expect exactly 256 handshakes.
- clr mid-word:
  - Stimulus: assert clr at chip 100 with HB full.
  - Expect m_valid=0 and s_ready=1 next cycle, words_out=0.
  - Expect a subsequent word to emit from its bit 0.
- Async reset mid-word:
  - Stimulus: drop rst_n between edges at chip 50.
  - Expect outputs at reset values immediately, without waiting for a clk edge.
  - Expect s_ready=1 one edge after release.
- Counter wrap:
  - Stimulus: CNT_W=2, WIDTH=8; send 5 words.
  - Expect words_out sequence 1,2,3,0,1.

Source files
------------

// File: rtl/chaos_serializer.sv
// rtl/chaos_serializer.sv - double-buffered chaos word serializer, LSB-first chip stream with end-of-word marker
module chaos_serializer #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_bit,
  output logic             m_last,
  output logic [CNT_W-1:0] words_out
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [WIDTH-1:0] hb_data;
  logic             hb_full;
  logic [WIDTH-1:0] sr_data;
  logic             sr_full;
  logic [IDX_W-1:0] idx;

  logic accept;
  logic chip_hs;
  logic last_hs;
  logic reload;
  logic hb_full_nx;

  // s_ready is registered from the next HB state, so it is never high while HB holds a word.
  always_comb begin
    accept     = s_valid && s_ready;
    chip_hs    = sr_full && m_ready;
    last_hs    = chip_hs && (idx == LAST_IDX);
    reload     = hb_full && (!sr_full || last_hs);
    hb_full_nx = hb_full;
    if (clr) begin
      hb_full_nx = 1'b0;
    end else if (accept) begin
      hb_full_nx = 1'b1;
    end else if (reload) begin
      hb_full_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_data <= '0;
      hb_full <= 1'b0;
      s_ready <= 1'b0;
    end else begin
      hb_full <= hb_full_nx;
      s_ready <= !hb_full_nx;
      if (!clr && accept) begin
        hb_data <= s_data;
      end
    end
  end

  // Reload on a last-chip handshake keeps words back-to-back with no idle chip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_data   <= '0;
      sr_full   <= 1'b0;
      idx       <= '0;
      words_out <= '0;
    end else if (clr) begin
      sr_data   <= '0;
      sr_full   <= 1'b0;
      idx       <= '0;
      words_out <= '0;
    end else begin
      if (last_hs) begin
        words_out <= words_out + CNT_W'(1);
      end
      if (reload) begin
        sr_data <= hb_data;
        sr_full <= 1'b1;
        idx     <= '0;
      end else if (chip_hs) begin
        sr_data <= sr_data >> 1;
        if (last_hs) begin
          sr_full <= 1'b0;
          idx     <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  assign m_bit   = sr_data[0];
  assign m_valid = sr_full;
  assign m_last  = sr_full && (idx == LAST_IDX);

endmodule

// File: tb/tb_chaos_serializer.sv
// tb/tb_chaos_serializer.sv - directed self-checking bench for chaos_serializer
module tb_chaos_serializer;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_bit;
  logic         m_last;
  logic [15:0]  words_out;

  logic         s_valid8 = 1'b0;
  logic         s_ready8;
  logic [7:0]   s_data8 = 8'h5A;
  logic         m_valid8;
  logic         m_ready8 = 1'b1;
  logic         m_bit8;
  logic         m_last8;
  logic [1:0]   words_out8;

  chaos_serializer #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_bit(m_bit), .m_last(m_last),
    .words_out(words_out)
  );

  chaos_serializer #(.WIDTH(8), .CNT_W(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8),
    .m_valid(m_valid8), .m_ready(m_ready8), .m_bit(m_bit8), .m_last(m_last8),
    .words_out(words_out8)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] upq[$];
  bit           up_hs = 1'b0;
  logic [511:0] got;
  logic [511:0] srh;
  int           cnt, ntarget, pat, cyc;
  int           last_bad, gaps, stall_bad;
  logic         prev_stall, prev_bit, prev_last;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One negedge: feed upstream from the queue, drive m_ready, record the chip about to be taken.
  task automatic step();
    @(negedge clk);
    if (up_hs) s_valid = 1'b0;
    if (!s_valid && upq.size() > 0) begin
      s_data  = upq.pop_front();
      s_valid = 1'b1;
    end
    up_hs = s_valid && s_ready;
    if (prev_stall && (m_bit !== prev_bit || m_last !== prev_last)) stall_bad++;
    m_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
    cyc++;
    if (m_valid && m_ready) begin
      got[cnt] = m_bit;
      srh[cnt] = s_ready;
      if (m_last !== ((cnt % W) == W - 1)) last_bad++;
      cnt++;
    end else if (!m_valid && cnt > 0 && cnt < ntarget) begin
      gaps++;
    end
    prev_stall = m_valid && !m_ready;
    prev_bit   = m_bit;
    prev_last  = m_last;
  endtask

  task automatic collect(input int n, input int p);
    ntarget = n; pat = p; cnt = 0; cyc = 0;
    last_bad = 0; gaps = 0; stall_bad = 0; prev_stall = 1'b0;
    got = '0; srh = '0;
    for (int i = 0; i < n * 4 + 20 && cnt < n; i++) step();
    chk("chip_count", W'(cnt), W'(n));
  endtask

  initial begin
    logic [W-1:0] w;
    int ones;
    int seq [5];
    int exp8 [5];
    int n8;
    logic [1:0] prev8;

    // Reset state
    #3;
    chk("rst_s_ready", W'(s_ready), '0);
    chk("rst_m_valid", W'(m_valid), '0);
    chk("rst_m_bit", W'(m_bit), '0);
    chk("rst_m_last", W'(m_last), '0);
    chk("rst_words_out", W'(words_out), '0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("release_s_ready_low", W'(s_ready), '0);
    @(negedge clk);
    chk("release_s_ready_high", W'(s_ready), W'(1));

    // Single word with latency check
    w = (W'(1) << 7) | W'(1);
    s_data = w; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    chk("lat_hb_full_s_ready", W'(s_ready), '0);
    chk("lat_m_valid_k", W'(m_valid), '0);
    @(negedge clk);
    chk("lat_m_valid_k1", W'(m_valid), W'(1));
    chk("lat_m_bit_k1", W'(m_bit), W'(1));
    chk("lat_s_ready_k1", W'(s_ready), W'(1));
    collect(256, 0);
    chk("single_bits", got[255:0], w);
    chk("single_last", W'(last_bad), '0);
    @(negedge clk);
    chk("single_words_out", W'(words_out), W'(1));
    chk("single_m_valid_after", W'(m_valid), '0);

    // Back-to-back: all-ones then all-zeros
    upq.push_back({W{1'b1}});
    upq.push_back('0);
    collect(512, 0);
    chk("b2b_word_a", got[255:0], {W{1'b1}});
    chk("b2b_word_b", got[511:256], '0);
    chk("b2b_gaps", W'(gaps), '0);
    chk("b2b_last", W'(last_bad), '0);
    ones = 0;
    for (int i = 0; i < 256; i++) ones += int'(srh[i]);
    chk("b2b_s_ready_while_hb_full", W'(ones), W'(1));
    chk("b2b_s_ready_after_reload", W'(srh[256]), W'(1));
    @(negedge clk);
    chk("b2b_words_out", W'(words_out), W'(3));

    // Backpressure with m_ready pattern 1,0,0,1
    upq.push_back(W'(8'hA5));
    collect(256, 1);
    chk("bp_first8", W'(got[7:0]), W'(8'hA5));
    chk("bp_bits", got[255:0], W'(8'hA5));
    chk("bp_stall_hold", W'(stall_bad), '0);
    chk("bp_last", W'(last_bad), '0);
    for (int i = 0; i < 12; i++) step();
    chk("bp_handshakes", W'(cnt), W'(256));
    chk("bp_words_out", W'(words_out), W'(4));

    // clr mid-word with HB full
    upq.push_back({64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978, 64'h1122334455667788});
    upq.push_back({W{1'b1}});
    collect(100, 0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_m_valid", W'(m_valid), '0);
    chk("clr_s_ready", W'(s_ready), W'(1));
    chk("clr_words_out", W'(words_out), '0);
    upq.push_back(W'(3'b110));
    collect(256, 0);
    chk("clr_next_word_bits", got[255:0], W'(3'b110));
    @(negedge clk);
    chk("clr_next_words_out", W'(words_out), W'(1));

    // Asynchronous reset mid-word
    upq.push_back({W{1'b1}});
    collect(50, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", W'(m_valid), '0);
    chk("arst_m_bit", W'(m_bit), '0);
    chk("arst_m_last", W'(m_last), '0);
    chk("arst_s_ready", W'(s_ready), '0);
    chk("arst_words_out", W'(words_out), '0);
    s_valid = 1'b0; up_hs = 1'b0; upq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_release_s_ready_low", W'(s_ready), '0);
    @(negedge clk);
    chk("arst_release_s_ready_high", W'(s_ready), W'(1));
    chk("arst_no_resume", W'(m_valid), '0);

    // Counter wrap on the WIDTH=8, CNT_W=2 instance
    exp8 = '{1, 2, 3, 0, 1};
    seq  = '{99, 99, 99, 99, 99};
    n8 = 0;
    prev8 = words_out8;
    s_valid8 = 1'b1;
    for (int i = 0; i < 200 && n8 < 5; i++) begin
      @(negedge clk);
      if (words_out8 !== prev8) begin
        seq[n8] = int'(words_out8);
        prev8 = words_out8;
        n8++;
      end
    end
    s_valid8 = 1'b0;
    for (int i = 0; i < 5; i++) chk($sformatf("wrap_seq%0d", i), W'(seq[i]), W'(exp8[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
